mux4_rr_arbiter: RTL and testbench
==================================

// Module: mux4_rr_arbiter
// PURPOSE
//  Round-robin arbiter and select sequencer for a shared 4:1 mux channel. Four requesters
//  contend for a single output path. The block grants one requester at a time and drives
//  the 2-bit mux select. It steers the granted requester's data onto dout, and sits
//  directly in front of the 4:1 mux datapath.
// PARAMETERS
//  DATA_W    1   width of each requester data lane and of dout
//  HOLD_MAX  4   max consecutive grant cycles per owner; used only with MUX4_ARB_HOLD_LIMIT_EN; legal 1..255
// PORTS
//  clk    in   1         single clock, rising edge
//  rst    in   1         asynchronous reset, active-high
//  req    in   4         request per requester; bit i = requester i
//  in0    in   DATA_W    requester 0 data
//  in1    in   DATA_W    requester 1 data
//  in2    in   DATA_W    requester 2 data
//  in3    in   DATA_W    requester 3 data
//  gnt    out  4         one-hot grant, registered; all-zero when idle
//  sel    out  2         registered mux select = index of current owner
//  busy   out  1         registered; 1 while a grant is held
//  dout   out  DATA_W    combinational: in[sel] when busy, else all-zero
// BEHAVIOUR
//  - Reset (async, any time):
//    - gnt=0, sel=2'b00, busy=0, dout=0, internal last_owner=2'b11, hold_cnt=0, state=IDLE.
//    - Reset mid-grant drops the grant immediately, without waiting for a clock edge.
//    - After reset, requester 0 has the highest priority.
//  - FSM states: IDLE (no owner) and GRANT (one owner). Everything is evaluated at the rising edge.
//  - Priority search:
//    - Scan from (last_owner+1) mod 4 upward, wrapping 3->0.
//    - The first asserted req bit wins. Indices are 2-bit, so the wrap is natural.
//  - IDLE:
//    - If any req bit is set, go to GRANT: gnt=onehot(winner), sel=winner, busy=1, last_owner=winner.
//    - Otherwise stay in IDLE.
//    - Latency: a req sampled at edge k is visible on gnt after edge k (1 cycle).
//  - GRANT:
//    - The owner keeps the grant while req[owner] is sampled high.
//    - When req[owner] is sampled low at an edge:
//      - If another req bit is set, grant it at that same edge (back-to-back, no idle cycle).
//      - Otherwise go to IDLE with gnt=0 and busy=0. sel holds its last value.
//    - A released owner is never re-granted at its release edge. It has the lowest priority in the next search.
//  - Simultaneous requests: resolved purely by round-robin order. No requester waits more
//    than 3 grant tenures (with the hold limit enabled).
//  - gnt, sel and busy are mutually consistent on every cycle: gnt==0 iff busy==0, and gnt==onehot(sel) when busy.
//  - dout is glitch-free relative to sel because it is driven from registered sel. It carries no storage.
//  - req bits of non-owners may toggle freely. Only their values at edges matter.
// CONFIGURATION
//  MUX4_ARB_HOLD_LIMIT_EN defined:
//    - An 8-bit hold_cnt counts cycles in GRANT. It is cleared to 1 on each new grant.
//    - When hold_cnt==HOLD_MAX and some other req bit is set, the grant is forced to the next
//      round-robin winner at that edge, even though req[owner] is still high.
//    - With no competing requester, the owner keeps the grant and hold_cnt saturates at HOLD_MAX.
//  MUX4_ARB_HOLD_LIMIT_EN undefined:
//    - No counter logic exists. The owner holds the grant indefinitely while req[owner] stays high.
//    - HOLD_MAX is ignored.
// TESTING
//  1. Reset, then req=4'b1111 held high -> gnt=0001 and sel=0 one edge later, held while req[0]=1
//     (macro off); drop req[0] -> next edge gnt=0010, sel=1, no idle cycle.
//  2. Round-robin wrap: owner=3, then req=4'b1001 and req[3] dropped -> gnt=0001 (wraps to 0), not 1000.
//  3. Single requester: req=4'b0100 pulse for 3 edges -> busy=1 for 3 cycles, dout=in2 while busy;
//     req=0 -> gnt=0, busy=0, dout=0, sel stays 2.
//  4. Reset asserted mid-grant (owner=1, in1=1) -> gnt, busy and dout go to 0 without a clock edge;
//     release reset with req=4'b0010 -> gnt=0010 next edge (priority restarts at 0, only 1 requesting).
//  5. MUX4_ARB_HOLD_LIMIT_EN, HOLD_MAX=4, req=4'b0011 constant -> gnt alternates 0001 x4 cycles,
//     0010 x4 cycles, repeating; req=4'b0001 only -> gnt=0001 held indefinitely.
//  6. Every cycle: assert gnt==0 iff busy==0, gnt==onehot(sel) when busy, and dout==in[sel] when busy else 0.

Source files
------------

// File: rtl/mux4_rr_arbiter.sv
// Round-robin arbiter and select sequencer for a shared 4:1 mux channel.
// Optional per-owner hold limit enabled by defining MUX4_ARB_HOLD_LIMIT_EN.
module mux4_rr_arbiter #(
   parameter int unsigned DATA_W   = 1,
   parameter int unsigned HOLD_MAX = 4
) (
   input  logic              clk,
   input  logic              rst,
   input  logic [3:0]        req,
   input  logic [DATA_W-1:0] in0,
   input  logic [DATA_W-1:0] in1,
   input  logic [DATA_W-1:0] in2,
   input  logic [DATA_W-1:0] in3,
   output logic [3:0]        gnt,
   output logic [1:0]        sel,
   output logic              busy,
   output logic [DATA_W-1:0] dout
);

   if (HOLD_MAX < 1 || HOLD_MAX > 255) begin : g_bad_hold
      $error("HOLD_MAX must be in 1..255");
   end

   typedef enum logic {
      IDLE  = 1'b0,
      GRANT = 1'b1
   } state_t;

   state_t     state, state_nxt;
   logic [3:0] gnt_nxt;
   logic [1:0] sel_nxt;
   logic       busy_nxt;
   logic [1:0] last_owner, last_owner_nxt;
   logic [3:0] cand;
   logic [1:0] winner;
   logic       found;

`ifdef MUX4_ARB_HOLD_LIMIT_EN
   localparam logic [7:0] HOLD_LIM = 8'(HOLD_MAX);
   logic [7:0] hold_cnt, hold_cnt_nxt;
   logic       hold_hit;
   assign hold_hit = (hold_cnt == HOLD_LIM);
`endif

   // The current owner is excluded from the search so it can never re-win its own slot
   assign cand = (state == GRANT) ? (req & ~gnt) : req;

   // Scan from last_owner+1 upward with natural 2-bit wrap; last_owner itself is last
   always_comb begin
      logic [1:0] idx;
      found  = 1'b0;
      winner = last_owner;
      for (int i = 1; i <= 4; i++) begin
         idx = last_owner + 2'(i);
         if (!found && cand[idx]) begin
            found  = 1'b1;
            winner = idx;
         end
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state      <= IDLE;
         gnt        <= 4'b0000;
         sel        <= 2'b00;
         busy       <= 1'b0;
         last_owner <= 2'b11;
`ifdef MUX4_ARB_HOLD_LIMIT_EN
         hold_cnt   <= 8'd0;
`endif
      end else begin
         state      <= state_nxt;
         gnt        <= gnt_nxt;
         sel        <= sel_nxt;
         busy       <= busy_nxt;
         last_owner <= last_owner_nxt;
`ifdef MUX4_ARB_HOLD_LIMIT_EN
         hold_cnt   <= hold_cnt_nxt;
`endif
      end
   end

   always_comb begin
      logic take;
      state_nxt      = state;
      gnt_nxt        = gnt;
      sel_nxt        = sel;
      busy_nxt       = busy;
      last_owner_nxt = last_owner;
      take           = 1'b0;
`ifdef MUX4_ARB_HOLD_LIMIT_EN
      hold_cnt_nxt   = hold_cnt;
`endif
      unique case (state)
         IDLE: begin
            take = found;
         end
         GRANT: begin
            if (!req[sel]) begin
               if (found) begin
                  take = 1'b1;
               end else begin
                  state_nxt = IDLE;
                  gnt_nxt   = 4'b0000;
                  busy_nxt  = 1'b0;
               end
`ifdef MUX4_ARB_HOLD_LIMIT_EN
            end else if (hold_hit && found) begin
               take = 1'b1;
            end else if (!hold_hit) begin
               hold_cnt_nxt = hold_cnt + 8'd1;
`endif
            end
         end
         default: begin
            state_nxt = IDLE;
         end
      endcase
      if (take) begin
         state_nxt      = GRANT;
         gnt_nxt        = 4'(4'b0001 << winner);
         sel_nxt        = winner;
         busy_nxt       = 1'b1;
         last_owner_nxt = winner;
`ifdef MUX4_ARB_HOLD_LIMIT_EN
         hold_cnt_nxt   = 8'd1;
`endif
      end
   end

   // Output steering from registered sel; no storage on the data path
   always_comb begin
      dout = '0;
      if (busy) begin
         unique case (sel)
            2'd0: dout = in0;
            2'd1: dout = in1;
            2'd2: dout = in2;
            2'd3: dout = in3;
            default: dout = '0;
         endcase
      end
   end

endmodule

// File: tb/tb_mux4_rr_arbiter.sv
// Self-checking bench for mux4_rr_arbiter: vector table plus reset and hold sequences,
// with expected outputs queued at drive time and compared after the sampling edge.
module tb_mux4_rr_arbiter;

   typedef struct {
      logic [3:0] req;
      logic [3:0] din;
      logic [3:0] gnt;
      logic [1:0] sel;
      logic       busy;
      logic       dout;
   } vec_t;

   logic       clk = 1'b0;
   logic       rst;
   logic [3:0] req;
   logic       in0, in1, in2, in3;
   logic [3:0] gnt;
   logic [1:0] sel;
   logic       busy;
   logic       dout;

   int   napplied = 0;
   int   nmiss    = 0;
   bit   done     = 1'b0;
   vec_t sb[$];

   mux4_rr_arbiter #(.DATA_W(1), .HOLD_MAX(4)) dut (
      .clk(clk), .rst(rst), .req(req),
      .in0(in0), .in1(in1), .in2(in2), .in3(in3),
      .gnt(gnt), .sel(sel), .busy(busy), .dout(dout)
   );

   always #5 clk = ~clk;

   // Cross-output consistency on every cycle
   always @(negedge clk) begin
      if (!done) begin
         logic [3:0] d;
         logic       want_dout;
         d = {in3, in2, in1, in0};
         want_dout = busy ? d[sel] : 1'b0;
         napplied++;
         if (((gnt == 4'b0000) != !busy) || (busy && gnt != (4'b0001 << sel)) || dout != want_dout) begin
            nmiss++;
            $display("FAIL invariant @%0t: gnt=%b sel=%0d busy=%b dout=%b, want gnt==0 iff !busy, gnt==onehot(sel), dout=%b",
                     $time, gnt, sel, busy, dout, want_dout);
         end
      end
   end

   // Drive one vector at the current negedge, then compare after the next rising edge
   task automatic step(input string name, input int idx, input vec_t v);
      vec_t e;
      req = v.req;
      {in3, in2, in1, in0} = v.din;
      sb.push_back(v);
      @(posedge clk);
      #1;
      e = sb.pop_front();
      napplied++;
      if (gnt !== e.gnt || sel !== e.sel || busy !== e.busy || dout !== e.dout) begin
         nmiss++;
         $display("FAIL %s[%0d]: got gnt=%b sel=%0d busy=%b dout=%b, want gnt=%b sel=%0d busy=%b dout=%b",
                  name, idx, gnt, sel, busy, dout, e.gnt, e.sel, e.busy, e.dout);
      end
   endtask

   task automatic check_idle(input string name);
      napplied++;
      if (gnt !== 4'b0000 || sel !== 2'b00 || busy !== 1'b0 || dout !== 1'b0) begin
         nmiss++;
         $display("FAIL %s: got gnt=%b sel=%0d busy=%b dout=%b, want gnt=0000 sel=0 busy=0 dout=0",
                  name, gnt, sel, busy, dout);
      end
   endtask

   function automatic vec_t mk(input logic [3:0] r, input logic [3:0] d, input logic [3:0] g,
                               input logic [1:0] s, input logic b, input logic o);
      vec_t v;
      v.req = r; v.din = d; v.gnt = g; v.sel = s; v.busy = b; v.dout = o;
      return v;
   endfunction

   vec_t vecs[22];

   initial begin
      //          req      din      gnt      sel  busy dout
      vecs[0]  = mk(4'b1111, 4'b0001, 4'b0001, 2'd0, 1, 1);
      vecs[1]  = mk(4'b1111, 4'b0000, 4'b0001, 2'd0, 1, 0);
      vecs[2]  = mk(4'b1110, 4'b0010, 4'b0010, 2'd1, 1, 1);
      vecs[3]  = mk(4'b1110, 4'b0000, 4'b0010, 2'd1, 1, 0);
      vecs[4]  = mk(4'b1101, 4'b0100, 4'b0100, 2'd2, 1, 1);
      vecs[5]  = mk(4'b1001, 4'b1000, 4'b1000, 2'd3, 1, 1);
      vecs[6]  = mk(4'b0001, 4'b0000, 4'b0001, 2'd0, 1, 0);
      vecs[7]  = mk(4'b1001, 4'b0001, 4'b0001, 2'd0, 1, 1);
      vecs[8]  = mk(4'b1000, 4'b0111, 4'b1000, 2'd3, 1, 0);
      vecs[9]  = mk(4'b1011, 4'b1000, 4'b1000, 2'd3, 1, 1);
      vecs[10] = mk(4'b0011, 4'b0000, 4'b0001, 2'd0, 1, 0);
      vecs[11] = mk(4'b0100, 4'b0100, 4'b0100, 2'd2, 1, 1);
      vecs[12] = mk(4'b0100, 4'b0000, 4'b0100, 2'd2, 1, 0);
      vecs[13] = mk(4'b0100, 4'b0100, 4'b0100, 2'd2, 1, 1);
      vecs[14] = mk(4'b0000, 4'b0100, 4'b0000, 2'd2, 0, 0);
      vecs[15] = mk(4'b0000, 4'b1111, 4'b0000, 2'd2, 0, 0);
      vecs[16] = mk(4'b0100, 4'b0100, 4'b0100, 2'd2, 1, 1);
      vecs[17] = mk(4'b0011, 4'b0001, 4'b0001, 2'd0, 1, 1);
      vecs[18] = mk(4'b0111, 4'b0000, 4'b0001, 2'd0, 1, 0);
      vecs[19] = mk(4'b0110, 4'b0010, 4'b0010, 2'd1, 1, 1);
      vecs[20] = mk(4'b0000, 4'b0010, 4'b0000, 2'd1, 0, 0);
      vecs[21] = mk(4'b1101, 4'b0100, 4'b0100, 2'd2, 1, 1);

      rst = 1'b1;
      req = 4'b0000;
      {in3, in2, in1, in0} = 4'b1111;
      repeat (2) @(negedge clk);
      #1 check_idle("reset_state");

      @(negedge clk);
      rst = 1'b0;
      step("vec", 0, vecs[0]);
      for (int i = 1; i < 22; i++) begin
         @(negedge clk);
         step("vec", i, vecs[i]);
      end

      // Owner 2 releases, only requester 1 left -> owner 1
      @(negedge clk);
      step("pre_rst", 0, mk(4'b0010, 4'b0010, 4'b0010, 2'd1, 1, 1));
      #2 rst = 1'b1;
      #1 check_idle("async_rst_a");
      @(negedge clk);
      rst = 1'b0;
      step("post_rst", 0, mk(4'b0010, 4'b0010, 4'b0010, 2'd1, 1, 1));

      // Reset again mid-grant of owner 1; priority must restart at 0, not after the old owner
      #2 rst = 1'b1;
      #1 check_idle("async_rst_b");
      @(negedge clk);
      rst = 1'b0;
      step("post_rst", 1, mk(4'b0110, 4'b0100, 4'b0010, 2'd1, 1, 0));

      // Two constant requesters from a fresh reset
      @(negedge clk);
      rst = 1'b1;
      @(negedge clk);
      rst = 1'b0;
      for (int i = 0; i < 12; i++) begin
`ifdef MUX4_ARB_HOLD_LIMIT_EN
         logic [3:0] g;
         g = ((i / 4) % 2 == 0) ? 4'b0001 : 4'b0010;
         step("hold_pair", i, mk(4'b0011, 4'b0011, g, (g == 4'b0001) ? 2'd0 : 2'd1, 1, 1));
`else
         step("hold_pair", i, mk(4'b0011, 4'b0011, 4'b0001, 2'd0, 1, 1));
`endif
         @(negedge clk);
      end
      for (int i = 0; i < 8; i++) begin
         step("hold_solo", i, mk(4'b0001, 4'b0001, 4'b0001, 2'd0, 1, 1));
         @(negedge clk);
      end

      done = 1'b1;
      $display("== %0d vectors applied, %0d miscompares ==", napplied, nmiss);
      $finish;
   end

endmodule
